// File: rtl/hist_peak_finder_pkg.sv
// Shared dToF histogram parameters. The histogram builder and the peak finder
// both import this package so that they agree on bank layout and count width.
package hist_peak_finder_pkg;

   localparam int HPF_NB        = 5;               // bin address width
   localparam int HPF_PIX_W     = 2;               // pixel index width
   localparam int HPF_CNT_W     = 8;               // bin count width
   localparam int HPF_THR       = 3;               // minimum peak count for a hit
   localparam int HPF_BIN_NUM   = 2 ** HPF_NB;     // bins per pixel
   localparam int HPF_PIXEL_NUM = 2 ** HPF_PIX_W;  // pixels per bank

endpackage : hist_peak_finder_pkg

// File: rtl/hist_peak_finder_if.sv
// Bundle between the peak finder, the histogram bank read port and the result
// consumer. The master side is the peak finder itself.
interface hist_peak_finder_if
   import hist_peak_finder_pkg::*;
#(
   parameter int NB    = HPF_NB,
   parameter int PIX_W = HPF_PIX_W,
   parameter int CNT_W = HPF_CNT_W
);

   // Bank-complete notification from the histogram builder
   logic                    his_done;
   logic                    done_bank;

   // Histogram read port, one cycle read latency
   logic                    rd_en;
   logic [PIX_W+NB:0]       rd_addr;
   logic [CNT_W-1:0]        rd_data;

   // Per-pixel result stream
   logic                    out_valid;
   logic                    out_ready;
   logic [PIX_W-1:0]        out_pixel;
   logic [NB-1:0]           out_peak_bin;
   logic [CNT_W-1:0]        out_peak_cnt;
   logic                    out_hit;

   // Status
   logic                    busy;
   logic                    overrun;

   modport master (
      input  his_done, done_bank, rd_data, out_ready,
      output rd_en, rd_addr, out_valid, out_pixel, out_peak_bin,
             out_peak_cnt, out_hit, busy, overrun
   );

   modport slave (
      output his_done, done_bank, rd_data, out_ready,
      input  rd_en, rd_addr, out_valid, out_pixel, out_peak_bin,
             out_peak_cnt, out_hit, busy, overrun
   );

endinterface : hist_peak_finder_if

// File: rtl/hist_peak_finder_peak_cmp.sv
// Running-maximum tracker. A qualified beat either loads unconditionally (first
// beat of a search) or replaces the held maximum only when strictly larger, so
// ties keep the earliest index. The outputs already include the current beat,
// letting the caller capture the final maximum in the same cycle as the last beat.
module hist_peak_finder_peak_cmp #(
   parameter int CNT_W = 8,
   parameter int NB    = 5
) (
   input  logic             clk_i,
   input  logic             qual_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] data_i,
   input  logic [NB-1:0]    bin_i,
   output logic [CNT_W-1:0] max_cnt_o,
   output logic [NB-1:0]    max_bin_o
);

   logic [CNT_W-1:0] max_cnt_q;
   logic [NB-1:0]    max_bin_q;
   logic             take;

   // Decide whether this beat becomes the new maximum
   always_comb begin
      take = qual_i && (load_i || (data_i > max_cnt_q));
   end

   // Hold the running maximum; pure datapath, restarted by the first-beat load
   always_ff @(posedge clk_i) begin
      if (take) begin
         max_cnt_q <= data_i;
         max_bin_q <= bin_i;
      end
   end

   assign max_cnt_o = take ? data_i : max_cnt_q;
   assign max_bin_o = take ? bin_i  : max_bin_q;

endmodule : hist_peak_finder_peak_cmp

// File: rtl/hist_peak_finder.sv
// Histogram peak finder. When a bank completes it reads every bin of every
// pixel in that bank, tracks the largest count per pixel and hands one result
// per pixel to the consumer over a registered valid/ready stream.
module hist_peak_finder
   import hist_peak_finder_pkg::*;
#(
   parameter int NB    = HPF_NB,
   parameter int PIX_W = HPF_PIX_W,
   parameter int CNT_W = HPF_CNT_W,
   parameter int THR   = HPF_THR
) (
   input  logic               clk,
   input  logic               res,
   hist_peak_finder_if.master bus
);

   localparam int PIXEL_NUM = 2 ** PIX_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_EMIT  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             bank_q, bank_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic [NB-1:0]    bin_q, bin_d;
   logic             ovr_q, ovr_d;
   logic             out_valid_q, out_valid_d;
   logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
   logic [NB-1:0]    out_bin_q, out_bin_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_hit_q, out_hit_d;
   logic             rd_en;

   // Read-return stage: marks which bin the returning rd_data belongs to
   logic             vld_p1_q;
   logic [NB-1:0]    bin_p1_q;
   logic             first_p1;

   logic [CNT_W-1:0] max_cnt;
   logic [NB-1:0]    max_bin;

   assign first_p1 = (bin_p1_q == '0);

   hist_peak_finder_peak_cmp #(
      .CNT_W (CNT_W),
      .NB    (NB)
   ) u_peak_cmp (
      .clk_i     (clk),
      .qual_i    (vld_p1_q),
      .load_i    (first_p1),
      .data_i    (bus.rd_data),
      .bin_i     (bin_p1_q),
      .max_cnt_o (max_cnt),
      .max_bin_o (max_bin)
   );

   // Next-state and read strobe decode for the scan sequencer
   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      pix_d       = pix_q;
      bin_d       = bin_q;
      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      out_bin_d   = out_bin_q;
      out_cnt_d   = out_cnt_q;
      out_hit_d   = out_hit_q;
      rd_en       = 1'b0;
      // A completion pulse can only start a scan from IDLE; anywhere else it is lost
      ovr_d       = ovr_q | (bus.his_done & (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (bus.his_done) begin
               bank_d  = bus.done_bank;
               pix_d   = '0;
               bin_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            rd_en = 1'b1;
            bin_d = bin_q + 1'b1;
            if (bin_q == '1) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The last bin's data is on rd_data now; max_* already folds it in
            out_valid_d = 1'b1;
            out_pixel_d = pix_q;
            out_bin_d   = max_bin;
            out_cnt_d   = max_cnt;
            out_hit_d   = (max_cnt >= CNT_W'(THR));
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (pix_q == PIX_W'(PIXEL_NUM - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  pix_d   = pix_q + 1'b1;
                  bin_d   = '0;
                  state_d = S_SCAN;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state, counters, sticky overrun and the registered result
   always_ff @(posedge clk) begin
      if (res) begin
         state_q     <= S_IDLE;
         bank_q      <= 1'b0;
         pix_q       <= '0;
         bin_q       <= '0;
         ovr_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_bin_q   <= '0;
         out_cnt_q   <= '0;
         out_hit_q   <= 1'b0;
         vld_p1_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         pix_q       <= pix_d;
         bin_q       <= bin_d;
         ovr_q       <= ovr_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_bin_q   <= out_bin_d;
         out_cnt_q   <= out_cnt_d;
         out_hit_q   <= out_hit_d;
         vld_p1_q    <= rd_en;
      end
   end

   // ---- stage p0 -> p1: bin index follows its read into the return cycle ----
   always_ff @(posedge clk) begin
      bin_p1_q <= bin_q;
   end

   assign bus.rd_en        = rd_en;
   assign bus.rd_addr      = {bank_q, pix_q, bin_q};
   assign bus.out_valid    = out_valid_q;
   assign bus.out_pixel    = out_pixel_q;
   assign bus.out_peak_bin = out_bin_q;
   assign bus.out_peak_cnt = out_cnt_q;
   assign bus.out_hit      = out_hit_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.overrun      = ovr_q;

endmodule : hist_peak_finder
